// File: rtl/state_seq_param.sv
// Instruction-cycle sequencer: fetch, operand fetch, execute, iterative multiply
// and interrupt entry states, with priority-encoded interrupt acceptance.
module state_seq_param #(
    parameter int DATA_W = 16,
    parameter int IRQ_N  = 4,
    localparam int CW = $clog2(DATA_W),
    localparam int VW = $clog2(IRQ_N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ack,
    input  logic             from_d,
    input  logic             to_d,
    input  logic             op_mul,
    input  logic             op_svc,
    input  logic             op_rit,
    input  logic [IRQ_N-1:0] irq,
    input  logic [IRQ_N-1:0] irq_mask,
    output logic [4:0]       state,
    output logic             mem_req,
    output logic [CW-1:0]    mul_cnt,
    output logic             ita,
    output logic             itf,
    output logic [VW-1:0]    it_vec
);

    typedef enum logic [4:0] {
        IF0   = 5'd0,  IF1   = 5'd1,  FF0   = 5'd2,  FF1  = 5'd3,
        FF2   = 5'd4,  TF0   = 5'd5,  TF1   = 5'd6,  EX0  = 5'd7,
        EX1   = 5'd8,  IT0   = 5'd9,  IT1   = 5'd10, IT2  = 5'd11,
        MUL1  = 5'd12, MUL2A = 5'd13, MUL2B = 5'd14, MUL3 = 5'd15,
        MUL4  = 5'd16
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   mul_cnt_r;
    logic            itf_r;
    logic            ita_r;
    logic [VW-1:0]   it_vec_r;
    logic            mem_req_r;
    logic            mem_req_nxt_s;
    logic            accept_s;
    logic            rit_s;
    logic [VW-1:0]   vec_nxt_s;
    logic [VW-1:0]   pri_vec_s;
    logic [IRQ_N-1:0] pend_bits_s;
    logic            pend_s;

    assign pend_bits_s = irq & ~irq_mask;
    assign pend_s      = |pend_bits_s;

    // Lowest-index pending channel wins; scanning downward leaves it last.
    always_comb begin
        pri_vec_s = {VW{1'b0}};
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (pend_bits_s[i]) begin
                pri_vec_s = VW'(i);
            end else begin
                pri_vec_s = pri_vec_s;
            end
        end
    end

    // Next-state and acceptance decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        rit_s       = 1'b0;
        vec_nxt_s   = pri_vec_s;
        case (state_r)
            IF0:   if (ack) state_nxt_s = IF1; else state_nxt_s = IF0;
            IF1: begin
                if (!from_d)    state_nxt_s = FF0;
                else if (!to_d) state_nxt_s = TF0;
                else            state_nxt_s = EX0;
            end
            FF0:   if (ack) state_nxt_s = FF1; else state_nxt_s = FF0;
            FF1:   state_nxt_s = FF2;
            FF2:   if (to_d) state_nxt_s = EX0; else state_nxt_s = TF0;
            TF0:   if (ack) state_nxt_s = TF1; else state_nxt_s = TF0;
            TF1:   state_nxt_s = EX0;
            EX0:   if (op_mul) state_nxt_s = MUL1; else state_nxt_s = EX1;
            EX1: begin
                if (op_rit) begin
                    rit_s       = 1'b1;
                    state_nxt_s = IF0;
                end else if (op_svc) begin
                    accept_s    = 1'b1;
                    vec_nxt_s   = VW'(IRQ_N);
                    state_nxt_s = IT0;
                end else if (pend_s && !itf_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = IT0;
                end else begin
                    state_nxt_s = IF0;
                end
            end
            IT0:   state_nxt_s = IT1;
            IT1:   if (ack) state_nxt_s = IT2; else state_nxt_s = IT1;
            IT2:   state_nxt_s = IF0;
            MUL1:  state_nxt_s = MUL2A;
            MUL2A: state_nxt_s = MUL2B;
            MUL2B: if (mul_cnt_r != {CW{1'b0}}) state_nxt_s = MUL2A; else state_nxt_s = MUL3;
            MUL3:  state_nxt_s = MUL4;
            MUL4:  state_nxt_s = EX1;
            default: state_nxt_s = IF0;
        endcase
    end

    // mem_req is registered from the next state so it lines up with state.
    always_comb begin
        mem_req_nxt_s = (state_nxt_s == IF0) || (state_nxt_s == FF0) ||
                        (state_nxt_s == TF0) || (state_nxt_s == IT1);
    end

    // State, counter and interrupt bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IF0;
            mul_cnt_r <= {CW{1'b0}};
            itf_r     <= 1'b0;
            ita_r     <= 1'b0;
            it_vec_r  <= {VW{1'b0}};
            mem_req_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            mem_req_r <= mem_req_nxt_s;
            ita_r     <= accept_s;
            if (accept_s) begin
                itf_r    <= 1'b1;
                it_vec_r <= vec_nxt_s;
            end else if (rit_s) begin
                itf_r    <= 1'b0;
            end
            if (state_r == MUL1) begin
                mul_cnt_r <= CW'(DATA_W - 1);
            end else if ((state_r == MUL2B) && (mul_cnt_r != {CW{1'b0}})) begin
                mul_cnt_r <= mul_cnt_r - CW'(1);
            end
        end
    end

    assign state   = state_r;
    assign mem_req = mem_req_r;
    assign mul_cnt = mul_cnt_r;
    assign ita     = ita_r;
    assign itf     = itf_r;
    assign it_vec  = it_vec_r;

endmodule

// File: tb/tb_state_seq_param.sv
// Directed bench for state_seq_param: expected states are queued as each step is
// driven and compared after the clock edge, plus spot checks of the side outputs.
module tb_state_seq_param;

    localparam int IN = 4;
    localparam logic [4:0] S_IF0 = 5'd0,  S_IF1 = 5'd1,  S_FF0 = 5'd2,  S_FF1 = 5'd3;
    localparam logic [4:0] S_FF2 = 5'd4,  S_TF0 = 5'd5,  S_TF1 = 5'd6,  S_EX0 = 5'd7;
    localparam logic [4:0] S_EX1 = 5'd8,  S_IT0 = 5'd9,  S_IT1 = 5'd10, S_IT2 = 5'd11;
    localparam logic [4:0] S_MUL1 = 5'd12, S_MUL2A = 5'd13, S_MUL2B = 5'd14;
    localparam logic [4:0] S_MUL3 = 5'd15, S_MUL4 = 5'd16;

    logic          clk = 1'b0;
    logic          reset, ack, from_d, to_d, op_mul, op_svc, op_rit;
    logic [IN-1:0] irq, irq_mask;
    logic [4:0]    state, state4;
    logic          mem_req, mem_req4, ita, ita4, itf, itf4;
    logic [3:0]    mul_cnt;
    logic [1:0]    mul_cnt4;
    logic [2:0]    it_vec, it_vec4;

    int checks   = 0;
    int failures = 0;
    int pairs4   = 0;

    typedef struct {
        string      tag;
        logic [4:0] st;
    } exp_t;
    exp_t exp_q[$];

    state_seq_param #(.DATA_W(16), .IRQ_N(IN)) u_dut (
        .clk(clk), .reset(reset), .ack(ack), .from_d(from_d), .to_d(to_d),
        .op_mul(op_mul), .op_svc(op_svc), .op_rit(op_rit), .irq(irq),
        .irq_mask(irq_mask), .state(state), .mem_req(mem_req), .mul_cnt(mul_cnt),
        .ita(ita), .itf(itf), .it_vec(it_vec)
    );

    state_seq_param #(.DATA_W(4), .IRQ_N(IN)) u_dut4 (
        .clk(clk), .reset(reset), .ack(ack), .from_d(from_d), .to_d(to_d),
        .op_mul(op_mul), .op_svc(op_svc), .op_rit(op_rit), .irq(irq),
        .irq_mask(irq_mask), .state(state4), .mem_req(mem_req4), .mul_cnt(mul_cnt4),
        .ita(ita4), .itf(itf4), .it_vec(it_vec4)
    );

    always #5 clk = ~clk;

    // Number of multiply iterations performed by the narrow instance.
    always @(posedge clk) begin
        if (state4 == S_MUL2A) pairs4 <= pairs4 + 1;
    end

    function automatic logic mreq_of(input logic [4:0] s);
        return (s == S_IF0) || (s == S_FF0) || (s == S_TF0) || (s == S_IT1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] exp_st);
        exp_t e;
        e.tag = tag;
        e.st  = exp_st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".state"}, 32'(state), 32'(e.st));
        chk({e.tag, ".mem_req"}, 32'(mem_req), 32'(mreq_of(e.st)));
    endtask

    initial begin
        logic [4:0] mm_seq [9];
        mm_seq = '{S_IF1, S_FF0, S_FF1, S_FF2, S_TF0, S_TF1, S_EX0, S_EX1, S_IF0};

        reset = 1'b1; ack = 1'b0; from_d = 1'b0; to_d = 1'b0;
        op_mul = 1'b0; op_svc = 1'b0; op_rit = 1'b0;
        irq = 4'b0000; irq_mask = 4'b0000;
        step("reset", S_IF0);
        chk("reset.mul_cnt", 32'(mul_cnt), 32'd0);
        chk("reset.itf", 32'(itf), 32'd0);
        chk("reset.ita", 32'(ita), 32'd0);
        chk("reset.it_vec", 32'(it_vec), 32'd0);
        reset = 1'b0;

        // Register-register op, two wait cycles in IF0.
        from_d = 1'b1; to_d = 1'b1;
        step("rr.w1", S_IF0);
        step("rr.w2", S_IF0);
        ack = 1'b1;
        step("rr.if1", S_IF1);
        step("rr.ex0", S_EX0);
        step("rr.ex1", S_EX1);
        ack = 1'b0;
        step("rr.if0", S_IF0);

        // Memory-memory op with immediate ack.
        from_d = 1'b0; to_d = 1'b0; ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) ack = 1'b0;
            step($sformatf("mm%0d", i), mm_seq[i]);
        end

        // Masked interrupt acceptance: lowest unmasked asserted is channel 3.
        from_d = 1'b1; to_d = 1'b1; irq = 4'b1010; irq_mask = 4'b0010;
        ack = 1'b1; step("irq.if1", S_IF1);
        ack = 1'b0; step("irq.ex0", S_EX0);
        step("irq.ex1", S_EX1);
        step("irq.it0", S_IT0);
        chk("irq.ita", 32'(ita), 32'd1);
        chk("irq.vec", 32'(it_vec), 32'd3);
        chk("irq.itf", 32'(itf), 32'd1);
        step("irq.it1", S_IT1);
        chk("irq.ita_pulse", 32'(ita), 32'd0);
        step("irq.it1w", S_IT1);
        ack = 1'b1; step("irq.it2", S_IT2);
        ack = 1'b0; step("irq.if0", S_IF0);

        // In service: same request is not accepted again.
        ack = 1'b1; step("ins.if1", S_IF1);
        ack = 1'b0; step("ins.ex0", S_EX0);
        step("ins.ex1", S_EX1);
        step("ins.if0", S_IF0);
        chk("ins.ita", 32'(ita), 32'd0);
        chk("ins.vec_hold", 32'(it_vec), 32'd3);

        // SVC accepted regardless of itf.
        op_svc = 1'b1;
        ack = 1'b1; step("svc.if1", S_IF1);
        ack = 1'b0; step("svc.ex0", S_EX0);
        step("svc.ex1", S_EX1);
        step("svc.it0", S_IT0);
        chk("svc.ita", 32'(ita), 32'd1);
        chk("svc.vec", 32'(it_vec), 32'd4);
        op_svc = 1'b0;
        step("svc.it1", S_IT1);
        ack = 1'b1; step("svc.it2", S_IT2);
        ack = 1'b0; step("svc.if0", S_IF0);

        // Return from interrupt outranks SVC and clears itf.
        op_rit = 1'b1; op_svc = 1'b1;
        ack = 1'b1; step("rit.if1", S_IF1);
        ack = 1'b0; step("rit.ex0", S_EX0);
        step("rit.ex1", S_EX1);
        step("rit.if0", S_IF0);
        chk("rit.itf", 32'(itf), 32'd0);
        chk("rit.ita", 32'(ita), 32'd0);
        op_rit = 1'b0; op_svc = 1'b0;

        // Everything masked: no acceptance.
        irq_mask = 4'b1111;
        ack = 1'b1; step("msk.if1", S_IF1);
        ack = 1'b0; step("msk.ex0", S_EX0);
        step("msk.ex1", S_EX1);
        step("msk.if0", S_IF0);
        chk("msk.itf", 32'(itf), 32'd0);

        // Unmasked: channel 1 is the lowest asserted.
        irq_mask = 4'b0000;
        ack = 1'b1; step("pri.if1", S_IF1);
        ack = 1'b0; step("pri.ex0", S_EX0);
        step("pri.ex1", S_EX1);
        step("pri.it0", S_IT0);
        chk("pri.vec", 32'(it_vec), 32'd1);
        step("pri.it1", S_IT1);
        ack = 1'b1; step("pri.it2", S_IT2);
        ack = 1'b0; step("pri.if0", S_IF0);

        // 16-iteration multiply; narrow instance runs 4 in parallel.
        irq = 4'b0000; op_mul = 1'b1;
        ack = 1'b1; step("mul.if1", S_IF1);
        ack = 1'b0; step("mul.ex0", S_EX0);
        step("mul.mul1", S_MUL1);
        for (int i = 0; i < 16; i++) begin
            step($sformatf("mul.a%0d", i), S_MUL2A);
            chk($sformatf("mul.cnta%0d", i), 32'(mul_cnt), 32'(15 - i));
            step($sformatf("mul.b%0d", i), S_MUL2B);
            chk($sformatf("mul.cntb%0d", i), 32'(mul_cnt), 32'(15 - i));
        end
        step("mul.mul3", S_MUL3);
        step("mul.mul4", S_MUL4);
        step("mul.ex1", S_EX1);
        chk("mul.cnt_hold", 32'(mul_cnt), 32'd0);
        step("mul.if0", S_IF0);
        chk("mul4.pairs", 32'(pairs4), 32'd4);
        chk("mul4.state", 32'(state4), 32'(S_IF0));
        chk("mul4.cnt", 32'(mul_cnt4), 32'd0);

        // Reset in MUL2B with mul_cnt=7 aborts the multiply.
        ack = 1'b1; step("rm.if1", S_IF1);
        ack = 1'b0; step("rm.ex0", S_EX0);
        step("rm.mul1", S_MUL1);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("rm.a%0d", i), S_MUL2A);
            step($sformatf("rm.b%0d", i), S_MUL2B);
        end
        step("rm.a8", S_MUL2A);
        step("rm.b8", S_MUL2B);
        chk("rm.cnt7", 32'(mul_cnt), 32'd7);
        chk("rm.itf_pre", 32'(itf), 32'd1);
        reset = 1'b1;
        step("rm.rst", S_IF0);
        chk("rm.cnt", 32'(mul_cnt), 32'd0);
        chk("rm.itf", 32'(itf), 32'd0);
        chk("rm.ita", 32'(ita), 32'd0);
        chk("rm.vec", 32'(it_vec), 32'd0);
        reset = 1'b0;
        step("rm.hold", S_IF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_seq_param.md
STATE_SEQ_PARAM -- requirements
Module: state_seq_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning multiplier operand width, equal to the number of MUL2 bit iterations, minimum 2.
REQ-002 SHALL have parameter IRQ_N, default 4, meaning external interrupt channel count, minimum 1.
REQ-003 SHALL have derived widths CW=$clog2(DATA_W) and VW=$clog2(IRQ_N+1).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 ack  in  1  memory acknowledge, sampled in wait states.
REQ-008 from_d, to_d  in  1 each  source/destination operand is register-direct.
REQ-009 op_mul, op_svc, op_rit  in  1 each  decoded instruction class, valid from IF1 to EX1.
REQ-010 irq  in  IRQ_N  level interrupt requests, bit 0 has highest priority.
REQ-011 irq_mask  in  IRQ_N  1 masks the channel.
REQ-012 state  out  5  encoded state, IF0=0, IF1=1, FF0=2, FF1=3, FF2=4, TF0=5, TF1=6, EX0=7, EX1=8, IT0=9, IT1=10, IT2=11, MUL1=12, MUL2A=13, MUL2B=14, MUL3=15, MUL4=16.
REQ-013 mem_req  out  1  high in IF0, FF0, TF0 and IT1.
REQ-014 mul_cnt  out  CW  remaining multiply iterations.
REQ-015 ita, itf  out  1 each  interrupt accepted (one-cycle pulse) / interrupt in service.
REQ-016 it_vec  out  VW  accepted vector: channel index, or IRQ_N for SVC.

Function
REQ-017 State and output transitions SHALL occur only on rising clk; all outputs SHALL be registered or decoded from registered state.
REQ-018 IF0 SHALL hold until ack=1, then go to IF1.
REQ-019 From IF1 the next state SHALL be FF0 if from_d=0; else TF0 if to_d=0; else EX0.
REQ-020 FF0 SHALL hold until ack=1, then go to FF1, then FF2 after one cycle.
REQ-021 From FF2 the next state SHALL be TF0 if to_d=0, else EX0.
REQ-022 TF0 SHALL hold until ack=1, then go to TF1, then EX0 after one cycle.
REQ-023 From EX0 the next state SHALL be MUL1 if op_mul=1, else EX1.
REQ-024 MUL1 SHALL load mul_cnt with DATA_W-1 and go to MUL2A.
REQ-025 MUL2A SHALL go to MUL2B.
REQ-026 In MUL2B, if mul_cnt!=0, mul_cnt SHALL decrement and the next state SHALL be MUL2A; if mul_cnt=0, the next state SHALL be MUL3.
REQ-027 The total MUL2A/MUL2B pairs per multiply SHALL be exactly DATA_W.
REQ-028 MUL3 SHALL go to MUL4, and MUL4 SHALL go to EX1.
REQ-029 mul_cnt SHALL hold its value outside MUL1/MUL2B.
REQ-030 pend SHALL be defined as |(irq & ~irq_mask).
REQ-031 In EX1, the first matching priority SHALL apply:
  (a) op_rit=1: clear itf, no acceptance, next state IF0;
  (b) op_svc=1: accept regardless of itf, it_vec=IRQ_N;
  (c) pend=1 and itf=0: accept, it_vec=lowest unmasked asserted index;
  (d) otherwise: next state IF0.
REQ-032 Acceptance SHALL pulse ita for exactly one cycle, coincident with the EX1->IT0 edge, and SHALL set itf.
REQ-033 it_vec SHALL be latched at acceptance and held until the next acceptance.
REQ-034 IT0 SHALL go to IT1; IT1 SHALL hold until ack=1, then go to IT2; IT2 SHALL go to IF0.
REQ-035 irq changes outside EX1 SHALL have no effect, and masked or deasserted requests SHALL NOT be remembered.
REQ-036 ack in non-wait states SHALL be ignored.

Reset
REQ-037 When reset=1 at a clk edge: state=IF0, mul_cnt=0, itf=0, ita=0, it_vec=0.
REQ-038 mem_req SHALL follow state (high after reset).
REQ-039 Reset SHALL take priority over every transition, including mid-MUL and mid-wait; it SHALL abort without completing.

Verification
REQ-040 Register-register op (from_d=to_d=1, ack in IF0 after 2 cycles) -> IF0,IF0,IF0,IF1,EX0,EX1,IF0; mem_req high only in IF0.
REQ-041 Memory-memory op with ack immediate -> IF0,IF1,FF0,FF1,FF2,TF0,TF1,EX0,EX1,IF0.
REQ-042 op_mul with DATA_W=16 -> 16 MUL2A/MUL2B pairs, mul_cnt 15..0, EX0-to-EX1 takes 36 cycles; repeat with DATA_W=4 -> 4 pairs.
REQ-043 IRQ_N=4, irq=4'b1010, mask=4'b0010 in EX1 -> ita pulse, it_vec=3, itf=1.
REQ-044 Next EX1 with irq still high -> no acceptance; op_svc then -> accepted, it_vec=4; op_rit -> itf=0, state IF0.
REQ-045 reset asserted in MUL2B with mul_cnt=7 -> next cycle state=IF0, mul_cnt=0, itf=0.
